usb_pkt_tx: RTL and testbench

- Link-layer packet assembler directly upstream of the UTMI transmit path.
- Builds token, data and handshake packets (PID byte, token field + CRC5, payload + CRC16) and streams them bytewise into the UTMI tx data/tx_valid inputs.
- Runs entirely in the 60 MHz UTMI byte-clock domain.

---
 rtl/usb_pkt_pkg.sv | 58 +++++
 rtl/usb_crc16.sv | 22 ++
 rtl/usb_pkt_tx.sv | 171 +++++++++++++++++
 tb/tb_usb_pkt_tx.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkt_pkg.sv
// usb_pkt_pkg: shared encodings for the USB link-layer packet transmitter.
// PID codes, packet types, CRC constants and tx FSM state encoding.
package usb_pkt_pkg;

  typedef enum logic [1:0] {
    PKT_TOKEN = 2'd0,
    PKT_DATA  = 2'd1,
    PKT_HS    = 2'd2,
    PKT_RSVD  = 2'd3
  } pkt_type_e;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [4:0]  CRC5_POLY    = 5'h05;
  localparam logic [4:0]  CRC5_INIT    = 5'h1F;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PID    = 3'd1,
    S_TOK0   = 3'd2,
    S_TOK1   = 3'd3,
    S_DATA   = 3'd4,
    S_CRC_LO = 3'd5,
    S_CRC_HI = 3'd6,
    S_FIN    = 3'd7
  } tx_state_e;

  typedef struct packed {
    pkt_type_e   typ;
    logic [3:0]  pid;
    logic [10:0] tok;
    logic        zlp;
  } tx_req_t;

  // Returns the 5-bit field in wire order: first-sent bit in bit 0.
  function automatic logic [4:0] crc5_field(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = CRC5_INIT;
    for (int i = 0; i < 11; i++) begin
      fb = c[4] ^ d[i];
      c  = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
    end
    c = ~c;
    return {c[0], c[1], c[2], c[3], c[4]};
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: combinational one-byte CRC16 step, LSB-first data order.
// Register is kept reflected so the complemented value goes out low byte first.
module usb_crc16
  import usb_pkt_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_i[i]) c = (c >> 1) ^ CRC16_POLY_R;
      else                  c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/usb_pkt_tx.sv
// usb_pkt_tx: token/data/handshake packet assembler feeding UTMI tx.
// Optional payload length limit via USB_PKT_TX_MAXLEN_CHK_EN.
module usb_pkt_tx
  import usb_pkt_pkg::*;
#(
  parameter int w       = 8,
  parameter int MAX_PAY = 1023
) (
  input  logic         clk_60mhz,
  input  logic         rst,
  input  logic         pkt_start,
  input  logic [1:0]   pkt_type,
  input  logic [3:0]   pkt_pid,
  input  logic [10:0]  tok_field,
  input  logic         pkt_zlp,
  input  logic [w-1:0] pay_data,
  input  logic         pay_valid,
  input  logic         pay_last,
  output logic         pay_ready,
  output logic [w-1:0] utmi_data,
  output logic         utmi_tx_valid,
  input  logic         utmi_tx_ready,
  output logic         busy,
  output logic         done,
  output logic         underrun_err
`ifdef USB_PKT_TX_MAXLEN_CHK_EN
  ,output logic        maxlen_err
`endif
);

  if (w != 8 || MAX_PAY < 1 || MAX_PAY > 1023) begin : g_param_chk
    $error("usb_pkt_tx: only w=8 and MAX_PAY in 1..1023");
  end

  tx_state_e   state_q, state_d;
  tx_req_t     req_q, req_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d, crc16_nx;
  logic [15:0] crc16_out;
  logic        xfer;

`ifdef USB_PKT_TX_MAXLEN_CHK_EN
  logic [9:0] cnt_q, cnt_d;
  logic       maxerr_q, maxerr_d;
  assign maxlen_err = maxerr_q;
`endif

  assign xfer      = utmi_tx_valid && utmi_tx_ready;
  assign crc16_out = ~crc16_q;

  usb_crc16 u_crc16 (
    .crc_i  (crc16_q),
    .data_i (pay_data),
    .crc_o  (crc16_nx)
  );

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    crc5_d        = crc5_q;
    crc16_d       = crc16_q;
    utmi_tx_valid = 1'b0;
    utmi_data     = '0;
    pay_ready     = 1'b0;
    busy          = (state_q != S_IDLE);
    done          = 1'b0;
    underrun_err  = 1'b0;
`ifdef USB_PKT_TX_MAXLEN_CHK_EN
    cnt_d         = cnt_q;
    maxerr_d      = maxerr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pkt_start && pkt_type != PKT_RSVD) begin
          req_d.typ = pkt_type_e'(pkt_type);
          req_d.pid = pkt_pid;
          req_d.tok = tok_field;
          req_d.zlp = pkt_zlp;
          crc16_d   = CRC16_INIT;
          state_d   = S_PID;
`ifdef USB_PKT_TX_MAXLEN_CHK_EN
          cnt_d     = '0;
`endif
        end
      end
      S_PID: begin
        utmi_tx_valid = 1'b1;
        utmi_data     = {~req_q.pid, req_q.pid};
        crc5_d        = crc5_field(req_q.tok);
        if (xfer) begin
          case (req_q.typ)
            PKT_TOKEN: state_d = S_TOK0;
            PKT_DATA:  state_d = req_q.zlp ? S_CRC_LO : S_DATA;
            PKT_HS:    state_d = S_FIN;
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_TOK0: begin
        utmi_tx_valid = 1'b1;
        utmi_data     = req_q.tok[7:0];
        if (xfer) state_d = S_TOK1;
      end
      S_TOK1: begin
        utmi_tx_valid = 1'b1;
        utmi_data     = {crc5_q, req_q.tok[10:8]};
        if (xfer) state_d = S_FIN;
      end
      S_DATA: begin
        utmi_tx_valid = 1'b1;
        utmi_data     = pay_data;
        if (utmi_tx_ready) begin
          if (pay_valid) begin
            pay_ready = 1'b1;
            crc16_d   = crc16_nx;
            if (pay_last) state_d = S_CRC_LO;
`ifdef USB_PKT_TX_MAXLEN_CHK_EN
            cnt_d = cnt_q + 10'd1;
            if (cnt_q == 10'(MAX_PAY) && !pay_last) begin
              underrun_err = 1'b1;
              maxerr_d     = 1'b1;
              state_d      = S_IDLE;
            end
`endif
          end else begin
            underrun_err = 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_CRC_LO: begin
        utmi_tx_valid = 1'b1;
        utmi_data     = crc16_out[7:0];
        if (xfer) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        utmi_tx_valid = 1'b1;
        utmi_data     = crc16_out[15:8];
        if (xfer) state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_60mhz or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_q    <= '0;
      crc5_q   <= CRC5_INIT;
      crc16_q  <= CRC16_INIT;
`ifdef USB_PKT_TX_MAXLEN_CHK_EN
      cnt_q    <= '0;
      maxerr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      crc5_q   <= crc5_d;
      crc16_q  <= crc16_d;
`ifdef USB_PKT_TX_MAXLEN_CHK_EN
      cnt_q    <= cnt_d;
      maxerr_q <= maxerr_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_pkt_tx.sv
// tb_usb_pkt_tx: randomized self-checking bench for usb_pkt_tx.
// Expected byte streams come from bitwise CRC models over the packet contents.
module tb_usb_pkt_tx;

  typedef logic [7:0] bq_t[$];

  logic        clk_60mhz = 1'b0;
  logic        rst;
  logic        pkt_start;
  logic [1:0]  pkt_type;
  logic [3:0]  pkt_pid;
  logic [10:0] tok_field;
  logic        pkt_zlp;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        pay_last;
  logic        pay_ready;
  logic [7:0]  utmi_data;
  logic        utmi_tx_valid;
  logic        utmi_tx_ready;
  logic        busy;
  logic        done;
  logic        underrun_err;
`ifdef USB_PKT_TX_MAXLEN_CHK_EN
  logic        maxlen_err;
`endif

  int ncmp = 0;
  int nerr = 0;

  always #8 clk_60mhz = ~clk_60mhz;

  usb_pkt_tx dut (
    .clk_60mhz     (clk_60mhz),
    .rst           (rst),
    .pkt_start     (pkt_start),
    .pkt_type      (pkt_type),
    .pkt_pid       (pkt_pid),
    .tok_field     (tok_field),
    .pkt_zlp       (pkt_zlp),
    .pay_data      (pay_data),
    .pay_valid     (pay_valid),
    .pay_last      (pay_last),
    .pay_ready     (pay_ready),
    .utmi_data     (utmi_data),
    .utmi_tx_valid (utmi_tx_valid),
    .utmi_tx_ready (utmi_tx_ready),
    .busy          (busy),
    .done          (done),
    .underrun_err  (underrun_err)
`ifdef USB_PKT_TX_MAXLEN_CHK_EN
    ,.maxlen_err   (maxlen_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reflected-register CRC5; result bit 0 is the first bit on the wire.
  function automatic logic [4:0] crc5_ref(input logic [10:0] t);
    logic [4:0] r;
    r = 5'h1F;
    for (int j = 0; j < 11; j++) begin
      if (r[0] ^ t[j]) r = (r >> 1) ^ 5'h14;
      else             r = r >> 1;
    end
    return ~r;
  endfunction

  // Textbook MSB-first CRC16 over the wire bitstream, then mapped to
  // wire-order bytes: {hi, lo} with lo sent first, each LSB first.
  function automatic logic [15:0] crc16_ref(input bq_t b);
    logic [15:0] r, rev;
    logic        fb;
    r = 16'hFFFF;
    foreach (b[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = r[15] ^ b[i][j];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    r = ~r;
    rev = {<<{r}};
    return rev;
  endfunction

  task automatic run_pkt(input logic [1:0] typ, input logic [3:0] pid,
                         input logic [10:0] tok, input logic zlp,
                         input int npay, input int rmode,
                         input int starve, input bit incr);
    bq_t         pay;
    bq_t         exp;
    logic [15:0] c16;
    logic [4:0]  c5;
    int          k, cyc, ph, nrdy, pidx;
    bit          rdy, pp, dat;
    dat = (typ == 2'd1);
    pay = {};
    exp = {};
    if (dat && !zlp)
      for (int i = 0; i < npay; i++)
        pay.push_back(incr ? 8'(i) : 8'($urandom));
    exp.push_back({~pid, pid});
    if (typ == 2'd0) begin
      c5 = crc5_ref(tok);
      exp.push_back(tok[7:0]);
      exp.push_back({c5, tok[10:8]});
    end else if (dat) begin
      if (starve >= 0) begin
        for (int i = 0; i < starve; i++) exp.push_back(pay[i]);
      end else begin
        foreach (pay[i]) exp.push_back(pay[i]);
        c16 = crc16_ref(pay);
        exp.push_back(c16[7:0]);
        exp.push_back(c16[15:8]);
      end
    end

    @(posedge clk_60mhz); #1;
    pkt_start     = 1'b1;
    pkt_type      = typ;
    pkt_pid       = pid;
    tok_field     = tok;
    pkt_zlp       = zlp;
    utmi_tx_ready = 1'($urandom_range(0, 1));
    @(negedge clk_60mhz);
    check("req_busy", busy, 0);
    check("req_valid", utmi_tx_valid, 0);

    k = 0; cyc = 0; ph = 0; nrdy = 0;
    while (ph < 3) begin
      @(posedge clk_60mhz); #1;
      pidx = k - 1;
      pp   = dat && !zlp && k >= 1 && pidx < npay;
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      utmi_tx_ready = rdy;
      pkt_start = (ph == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      pkt_type  = 2'($urandom);
      pkt_pid   = 4'($urandom);
      tok_field = 11'($urandom);
      pkt_zlp   = 1'($urandom);
      if (pp) begin
        pay_data  = pay[pidx];
        pay_valid = (pidx != starve);
        pay_last  = (pidx == npay - 1);
      end else begin
        pay_data  = 8'($urandom);
        pay_valid = 1'($urandom);
        pay_last  = 1'($urandom);
      end
      @(negedge clk_60mhz);
      cyc++;
      if (ph == 0) begin
        check("tx_valid", utmi_tx_valid, 1);
        check("busy", busy, 1);
        check("done_low", done, 0);
        if (pp && pidx == starve) begin
          check("pay_ready_starve", pay_ready, 0);
          check("underrun", underrun_err, rdy);
          if (rdy) ph = 2;
        end else begin
          check("underrun_low", underrun_err, 0);
          check("pay_ready", pay_ready, pp && rdy);
          check("tx_byte", utmi_data, exp[k]);
          if (pay_ready) nrdy++;
          if (rdy) k++;
          if (starve < 0 && k == exp.size()) ph = 1;
        end
      end else if (ph == 1) begin
        check("fin_done", done, 1);
        check("fin_valid", utmi_tx_valid, 0);
        check("fin_busy", busy, 1);
        check("pay_ready_cnt", nrdy, pay.size());
        ph = 3;
      end else begin
        check("abort_valid", utmi_tx_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        ph = 3;
      end
      if (cyc > 400) begin
        check("timeout", 0, 1);
        ph = 3;
      end
    end

    @(posedge clk_60mhz); #1;
    pkt_start     = 1'b0;
    utmi_tx_ready = 1'($urandom_range(0, 1));
    @(negedge clk_60mhz);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", utmi_tx_valid, 0);
  endtask

  initial begin
    logic [1:0]  typ;
    logic        zlp;
    int          npay, starve;

    rst = 1'b0;
    pkt_start = 1'b0; pkt_type = 2'd0; pkt_pid = 4'h0;
    tok_field = 11'h0; pkt_zlp = 1'b0;
    pay_data = 8'h0; pay_valid = 1'b0; pay_last = 1'b0;
    utmi_tx_ready = 1'b0;
    #1;
    check("rst_valid", utmi_tx_valid, 0);
    check("rst_data", utmi_data, 0);
    check("rst_pay_ready", pay_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun_err, 0);
    repeat (2) @(posedge clk_60mhz);
    #1 rst = 1'b1;

    run_pkt(2'd0, 4'hD, 11'h000, 1'b0, 0, 0, -1, 1'b0);
    run_pkt(2'd2, 4'h2, 11'h000, 1'b0, 0, 0, -1, 1'b0);
    run_pkt(2'd1, 4'h3, 11'h000, 1'b1, 0, 0, -1, 1'b0);
    run_pkt(2'd1, 4'hB, 11'h000, 1'b1, 0, 1, -1, 1'b0);
    run_pkt(2'd1, 4'h3, 11'h000, 1'b0, 4, 1, -1, 1'b1);
    run_pkt(2'd1, 4'hB, 11'h000, 1'b0, 6, 0, 2, 1'b0);
    run_pkt(2'd0, 4'h9, 11'h7A5, 1'b0, 0, 1, -1, 1'b0);

    @(posedge clk_60mhz); #1;
    pkt_start = 1'b1; pkt_type = 2'd3;
    @(posedge clk_60mhz); #1;
    pkt_start = 1'b0;
    @(negedge clk_60mhz);
    check("rsvd_busy", busy, 0);
    check("rsvd_valid", utmi_tx_valid, 0);

    @(posedge clk_60mhz); #1;
    pkt_start = 1'b1; pkt_type = 2'd1; pkt_pid = 4'h3; pkt_zlp = 1'b0;
    @(posedge clk_60mhz); #1;
    pkt_start = 1'b0; utmi_tx_ready = 1'b1;
    pay_valid = 1'b1; pay_data = 8'h55; pay_last = 1'b0;
    repeat (3) @(posedge clk_60mhz);
    #3;
    check("pre_rst_valid", utmi_tx_valid, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", utmi_tx_valid, 0);
    check("mid_rst_data", utmi_data, 0);
    check("mid_rst_pay_ready", pay_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_underrun", underrun_err, 0);
    @(posedge clk_60mhz); #1;
    rst = 1'b1;
    pay_valid = 1'b0;
    run_pkt(2'd2, 4'h2, 11'h000, 1'b0, 0, 0, -1, 1'b0);

    for (int n = 0; n < 25; n++) begin
      typ    = 2'($urandom_range(0, 2));
      zlp    = (typ == 2'd1) ? ($urandom_range(0, 3) == 0) : 1'($urandom);
      npay   = $urandom_range(1, 16);
      starve = (typ == 2'd1 && !zlp && $urandom_range(0, 3) == 0)
               ? $urandom_range(0, npay - 1) : -1;
      run_pkt(typ, 4'($urandom), 11'($urandom), zlp, npay, 2, starve, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
